// File: rtl/control_sequencer_if.sv
// Handshake/status bundle between the main control FSM and control decode.
// master: sequencer side (drives state/flags/counters); slave: consumer side.
interface control_sequencer_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic [3:0]         state;
  logic               instr_done;
  logic               illegal_op;
  logic               mem_timeout;
  logic [COUNT_W-1:0] cycle_count;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  opcode,
    input  mem_ready,
    output state,
    output instr_done,
    output illegal_op,
    output mem_timeout,
    output cycle_count,
    output instr_count
  );

  modport slave (
    output opcode,
    output mem_ready,
    input  state,
    input  instr_done,
    input  illegal_op,
    input  mem_timeout,
    input  cycle_count,
    input  instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// Multicycle CPU main control FSM: IF, RF, class-specific execute/mem/wb.
// Ports: clk, rst_n (async active-low), bus (control_sequencer_if.master):
//   opcode/mem_ready in; state, instr_done, illegal_op, mem_timeout,
//   cycle_count/instr_count out (counters only with CONTROL_SEQUENCER_PERF_EN,
//   otherwise driven 0).
module control_sequencer #(
  parameter int COUNT_W   = 32,
  parameter int STALL_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_RF     = 4'd1,
    S_IMM3   = 4'd2,
    S_ALUR3  = 4'd3,
    S_ALURI3 = 4'd4,
    S_ALU4   = 4'd5,
    S_BR3    = 4'd6,
    S_MEM3   = 4'd7,
    S_LD4    = 4'd8,
    S_ST4    = 4'd9,
    S_LD5    = 4'd10,
    S_JMP3   = 4'd11
  } state_e;

  localparam int SW =
    (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STALL_MAX);

  state_e        state_q, state_d;
  logic [SW-1:0] stall_q, stall_d, stall_inc;
  logic          ill_q, ill_d;
  logic          to_q, to_d;
  logic          done;

  logic [5:0] op;
  logic       mr;
  logic       c_alu_r, c_alu_ri, c_br, c_mem;
  logic       c_jmp, c_imm;

  assign op = bus.opcode;
  assign mr = bus.mem_ready;

  assign c_alu_r  = (op[5:4] == 2'b00);
  assign c_alu_ri = (op[5:4] == 2'b01);
  assign c_br     = (op[5:3] == 3'b100);
  assign c_mem    = (op[5:3] == 3'b101);
  assign c_jmp    = (op == 6'b110000);
  assign c_imm    = (op == 6'b110001);

  // Saturating increment of the wait counter.
  assign stall_inc =
    (stall_q == SMAX) ? stall_q : stall_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      stall_q <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  end

  // done is decoded from registered state plus inputs that are stable
  // between edges, so it only changes right after a clock edge.
  always_comb begin
    state_d = state_q;
    stall_d = '0;
    ill_d   = ill_q;
    done    = 1'b0;
    case (state_q)
      S_IF: state_d = S_RF;
      S_RF: begin
        unique case (1'b1)
          c_alu_r:  state_d = S_ALUR3;
          c_alu_ri: state_d = S_ALURI3;
          c_br:     state_d = S_BR3;
          c_mem:    state_d = S_MEM3;
          c_jmp:    state_d = S_JMP3;
          c_imm:    state_d = S_IMM3;
          default: begin
            state_d = S_IF;
            ill_d   = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      S_ALUR3, S_ALURI3: state_d = S_ALU4;
      S_MEM3: state_d = op[2] ? S_ST4 : S_LD4;
      S_LD4: begin
        if (mr) state_d = S_LD5;
        else    stall_d = stall_inc;
      end
      S_ST4: begin
        if (mr) begin
          state_d = S_IF;
          done    = 1'b1;
        end else begin
          stall_d = stall_inc;
        end
      end
      S_ALU4, S_BR3, S_LD5, S_JMP3, S_IMM3: begin
        state_d = S_IF;
        done    = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    to_d = to_q | (stall_d == SMAX);
  end

  assign bus.state       = state_q;
  assign bus.instr_done  = done;
  assign bus.illegal_op  = ill_q;
  assign bus.mem_timeout = to_q;

`ifdef CONTROL_SEQUENCER_PERF_EN
  logic [COUNT_W-1:0] cyc_q, ins_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + COUNT_W'(1);
      ins_q <= ins_q + COUNT_W'(done);
    end
  end

  assign bus.cycle_count = cyc_q;
  assign bus.instr_count = ins_q;
`else
  assign bus.cycle_count = '0;
  assign bus.instr_count = '0;
`endif

endmodule
